clk_en_bank: RTL
================

// Module: clk_en_bank
// PURPOSE
//  Synthesisable N-channel clock-enable/divided-clock generator, all channels driven from one clock.
//  Replaces free-running behavioural clock generation (500M..1M ladders) in designs and benches.
//  Per channel: one-cycle tick strobe and registered square wave; divide ratio set at runtime.
//  Ratio updates are glitch-free; a global sync phase-aligns all channels.
// PARAMETERS
//  NUM_CH       6                      number of channels (1..16)
//  CNT_W        16                     counter / divide-ratio width
//  DEF_DIV_VEC  {500,50,10,5,2,1}      packed NUM_CH*CNT_W reset ratios; ch0 in LSBs
// PORTS
//  clk          in   1                 single clock
//  rst_n        in   1                 asynchronous active-low reset
//  en_i         in   NUM_CH            per-channel run enable
//  sync_i       in   1                 restart all channels phase-aligned
//  cfg_vld_i    in   1                 config write request
//  cfg_rdy_o    out  1                 config write accepted when vld&rdy
//  cfg_ch_i     in   $clog2(NUM_CH)    target channel
//  cfg_div_i    in   CNT_W             new divide ratio D
//  cfg_err_o    out  1                 one-cycle pulse: rejected write
//  tick_o       out  NUM_CH            one-cycle strobe per D enabled cycles
//  clk_o        out  NUM_CH            registered divided clock
// BEHAVIOUR
//  - Reset (async assert, sync release by caller): cnt=0, div=DEF_DIV_VEC, pending=0, tick_o=0, clk_o=0, cfg_err_o=0; cfg_rdy_o=1.
//  - Counter: cnt runs 0..D-1 and wraps, advancing once per cycle while en_i[ch]=1.
//  - tick_o: with en high from release, asserted in cycles D,2D,3D.. (cycle 1 = first edge after release).
//    D=1 -> tick every cycle.
//  - clk_o: registered, high for the first floor(D/2) counts of each period, low for the rest.
//    D=1 -> clk_o stays 0.
//  - en_i low: cnt held 0, tick_o=0, clk_o=0 next cycle. Re-enable restarts from cnt 0 (first tick after D cycles).
//  - Config: one-deep shadow per channel. Write sets shadow and pending[ch].
//    cfg_rdy_o = !pending[cfg_ch_i] (combinational).
//    Shadow applied at channel wrap, at sync_i, or immediately if the channel is disabled; pending then clears.
//    The period in progress always completes at the old D.
//  - Errors: cfg_div_i=0 or cfg_ch_i>=NUM_CH -> write accepted (rdy=1), no state change, cfg_err_o pulses 1 cycle.
//  - sync_i: next cycle every enabled cnt=0, all pending shadows applied, no tick that cycle, clk_o=0.
//    sync_i with a wrap in the same cycle: sync wins, tick suppressed.
//    Config write on a sync cycle: lands in the shadow, applied at the next wrap.
//  - Reset mid-period: all outputs 0 immediately; pending writes discarded.
// CONFIGURATION
//  CLK_EN_BANK_PHASE_EN defined:
//   - adds cfg_phase_i in CNT_W, written alongside cfg_div_i; applied with the shadow.
//   - At sync or enable the counter starts at phase P instead of 0, so the first tick arrives after D-P cycles.
//   - P>=D -> cfg_err_o pulse, write dropped.
//  Undefined: port absent, phase fixed 0.
// STRUCTURE
//  - Package clk_en_pkg: cnt_t (logic [CNT_W-1:0]), ch_cfg_t struct {div, phase, pending}, CH_IDX_W = $clog2(NUM_CH).
//  - Sub-module clk_en_ch: one channel (counter, shadow, tick/clk_o registers), instantiated NUM_CH times in a generate loop.
//  - Top holds config decode/error logic and the cfg_rdy_o mux.
// TESTING
//  1. Defaults, en all 1, 1000 cycles -> tick periods 1,2,5,10,50,500; clk_o[2] 2 high/3 low; clk_o[0] stays 0.
//  2. ch3 at cnt 4, write D=7 -> one tick at old period 10, then period 7.
//     Second write to ch3 before apply -> cfg_rdy_o=0 until apply.
//  3. Write div=0, then write ch=6 -> cfg_err_o one-cycle pulse each; tick periods unchanged.
//  4. sync_i pulse mid-period -> no tick that cycle; ticks on ch1/ch2/ch3 coincide 10 cycles later.
//  5. en_i[4] low 20 cycles with pending D=25 -> tick_o/clk_o 0 while low; after re-enable period 25.
//  6. rst_n low mid-period (async, between edges) -> outputs 0 at once; after release defaults restored.
//     With CLK_EN_BANK_PHASE_EN: D=10, P=3 -> first tick 7 cycles after sync.

Source files
------------

// File: rtl/clk_en_pkg.sv
// Shared types and default configuration for the clk_en_bank clock-enable generator.
package clk_en_pkg;

    localparam int DEF_NUM_CH = 6;
    localparam int DEF_CNT_W  = 16;
    localparam int CH_IDX_W   = $clog2(DEF_NUM_CH);

    typedef logic [DEF_CNT_W-1:0] cnt_t;

    typedef struct packed {
        cnt_t div;
        cnt_t phase;
        logic pending;
    } ch_cfg_t;

    // Channel 0 occupies the least significant slice.
    localparam logic [DEF_NUM_CH*DEF_CNT_W-1:0] DEF_DIV_VEC_DFLT =
        {16'd500, 16'd50, 16'd10, 16'd5, 16'd2, 16'd1};

endpackage

// File: rtl/clk_en_ch.sv
// One clock-enable channel: wrap counter, one-deep ratio shadow, registered tick and square wave.
module clk_en_ch #(
    parameter int               CNT_W   = 16,
    parameter logic [CNT_W-1:0] DEF_DIV = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] wr_div_i,
    input  logic [CNT_W-1:0] wr_phase_i,
    output logic             pending_o,
    output logic             tick_o,
    output logic             clk_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] sh_div_q, sh_phase_q;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             clk_q, clk_d;
    logic             wrap;
    logic             apply;

    assign wrap = en_i && (cnt_q >= (div_q - CNT_W'(1)));

    always_comb begin
        apply   = pend_q && (!en_i || sync_i || wrap);
        div_d   = div_q;
        phase_d = phase_q;
        pend_d  = pend_q;
        if (apply) begin
            div_d   = sh_div_q;
            phase_d = sh_phase_q;
            pend_d  = 1'b0;
        end
        // A stopped channel has no period in progress, so a write takes effect at once.
        if (wr_i) begin
            if (!en_i) begin
                div_d   = wr_div_i;
                phase_d = wr_phase_i;
            end else begin
                pend_d  = 1'b1;
            end
        end

        cnt_d  = cnt_q + CNT_W'(1);
        tick_d = 1'b0;
        clk_d  = 1'b0;
        if (!en_i || sync_i) begin
            cnt_d = phase_d;
        end else if (wrap) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            clk_d  = (div_d >> 1) != '0;
        end else begin
            clk_d = cnt_d < (div_d >> 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            div_q      <= DEF_DIV;
            phase_q    <= '0;
            sh_div_q   <= '0;
            sh_phase_q <= '0;
            pend_q     <= 1'b0;
            tick_q     <= 1'b0;
            clk_q      <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            phase_q <= phase_d;
            pend_q  <= pend_d;
            tick_q  <= tick_d;
            clk_q   <= clk_d;
            if (wr_i) begin
                sh_div_q   <= wr_div_i;
                sh_phase_q <= wr_phase_i;
            end
        end
    end

    assign pending_o = pend_q;
    assign tick_o    = tick_q;
    assign clk_o     = clk_q;

endmodule

// File: rtl/clk_en_bank.sv
// N-channel clock-enable / divided-clock bank with runtime ratio config and global phase sync.
// Optional per-channel start phase enabled by defining CLK_EN_BANK_PHASE_EN.
module clk_en_bank
    import clk_en_pkg::*;
#(
    parameter int                      NUM_CH      = DEF_NUM_CH,
    parameter int                      CNT_W       = DEF_CNT_W,
    parameter logic [NUM_CH*CNT_W-1:0] DEF_DIV_VEC = DEF_DIV_VEC_DFLT,
    localparam int                     CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en_i,
    input  logic              sync_i,
    input  logic              cfg_vld_i,
    output logic              cfg_rdy_o,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [CNT_W-1:0]  cfg_div_i,
`ifdef CLK_EN_BANK_PHASE_EN
    input  logic [CNT_W-1:0]  cfg_phase_i,
`endif
    output logic              cfg_err_o,
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] clk_o
);

    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] wr;
    logic [CNT_W-1:0]  phase_w;
    logic              ch_ok;
    logic              bad;
    logic              fire;
    logic              err_q;

`ifdef CLK_EN_BANK_PHASE_EN
    assign phase_w = cfg_phase_i;
`else
    assign phase_w = '0;
`endif

    // Out-of-range channels are always accepted so the error pulse can be reported.
    assign ch_ok     = int'(cfg_ch_i) < NUM_CH;
    assign cfg_rdy_o = ch_ok ? ~pend[cfg_ch_i] : 1'b1;
    assign bad       = !ch_ok || (cfg_div_i == '0) || (phase_w >= cfg_div_i);
    assign fire      = cfg_vld_i && cfg_rdy_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= fire && bad;
        end
    end

    assign cfg_err_o = err_q;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign wr[gi] = fire && !bad && (int'(cfg_ch_i) == gi);

            clk_en_ch #(
                .CNT_W   (CNT_W),
                .DEF_DIV (DEF_DIV_VEC[gi*CNT_W +: CNT_W])
            ) u_ch (
                .clk        (clk),
                .rst_n      (rst_n),
                .en_i       (en_i[gi]),
                .sync_i     (sync_i),
                .wr_i       (wr[gi]),
                .wr_div_i   (cfg_div_i),
                .wr_phase_i (phase_w),
                .pending_o  (pend[gi]),
                .tick_o     (tick_o[gi]),
                .clk_o      (clk_o[gi])
            );
        end
    endgenerate

endmodule
